sdram_burst_sched: RTL and testbench
====================================

// Module: sdram_burst_sched
// PURPOSE
//   Burst request scheduler sitting directly upstream of the SDRAM controller.
//   Watches the camera write-FIFO and display read-FIFO fill levels, raises
//   wr_sdram_req / rd_sdram_req, and holds it until the controller's 1-cycle ack.
//   Supplies burst base addresses with double-buffered (ping-pong) frame banks,
//   so the display always reads the last completely written frame.
// PARAMETERS
//   BURST_LEN    512     words per burst; must match the controller's fixed burst
//   FRAME_WORDS  307200  16-bit words per frame (640x480); multiple of BURST_LEN
//   PTR_W        19      frame pointer width; 2**PTR_W >= FRAME_WORDS
//   FIFO_AW      10      width of the FIFO used-word counts
//   RD_LOW       256     read request when rd_fifo_usedw < RD_LOW
// PORTS
//   clk            in   1         system/SDRAM clock
//   rst            in   1         asynchronous reset, active-high
//   init_done      in   1         controller init complete; no requests before this
//   wr_fifo_usedw  in   FIFO_AW   camera write-FIFO fill level
//   rd_fifo_usedw  in   FIFO_AW   display read-FIFO fill level
//   wr_frame_start in   1         1-cycle pulse, camera vsync (start of new frame)
//   rd_frame_start in   1         1-cycle pulse, display vsync
//   wr_sdram_ack   in   1         1-cycle pulse, write burst finished
//   rd_sdram_ack   in   1         1-cycle pulse, read burst finished
//   wr_sdram_req   out  1         write burst request (level, held until ack)
//   rd_sdram_req   out  1         read burst request (level, held until ack)
//   wr_addr        out  PTR_W+1   {wr_bank, wr_ptr}: write burst base address
//   rd_addr        out  PTR_W+1   {rd_bank, rd_ptr}: read burst base address
// BEHAVIOUR
//   Reset: both reqs=0, wr_ptr=rd_ptr=0, wr_bank=0, rd_bank=1, last_wr=0; FSM=S_IDLE.
//     Async assert clears everything, including mid-burst; a late ack is ignored.
//   FSM states: S_IDLE, S_WR, S_RD, S_GAP.
//   S_IDLE (init_done=1 only): wr_need = wr_fifo_usedw >= BURST_LEN;
//     rd_need = rd_fifo_usedw < RD_LOW.
//     Only one need -> go to its state. Both -> priority alternates: after a
//     write burst, read wins next; after a read, write wins; last_wr starts 0,
//     so write wins first. Neither -> stay.
//   S_WR: wr_sdram_req=1 (registered, asserted the cycle after the decision).
//     Address is frozen. On wr_sdram_ack: req=0 same edge;
//     wr_ptr += BURST_LEN, wrapping to 0 when it reaches FRAME_WORDS;
//     last_wr=1; go to S_GAP.
//   S_RD: same for rd_sdram_req / rd_sdram_ack / rd_ptr; last_wr=0.
//   S_GAP: 2 cycles with no request, so the controller returns to idle; then
//     S_IDLE.
//   Only one req is ever high. A req never drops without its ack.
//   Ack of the non-active type is ignored.
//   Frame switching:
//     wr_frame_start: wr_ptr=0; wr_bank toggles; done_bank <= old wr_bank.
//     rd_frame_start: rd_ptr=0; rd_bank <= done_bank.
//     If the pulse arrives while the matching req is high, it is latched
//     pending and applied on the ack edge, after the ptr increment (overrides
//     it). Two pulses before the ack collapse to one.
//   wr_frame_start and ack on the same edge: frame start takes precedence.
//   wr_ptr wraps at FRAME_WORDS even without vsync (no overrun into the other bank).
//   init_done falling: finish the current handshake, then hold in S_IDLE.
// TESTING
//   T1 reset, init_done=1, wr_usedw=512, rd_usedw=600 -> wr_req 1 cycle later,
//      wr_addr=0; ack -> req=0 same edge, wr_addr=0x00200.
//   T2 both needs true repeatedly, ack after 520 cycles -> order W,R,W,R;
//      2 idle cycles between reqs; reqs never overlap.
//   T3 600 write bursts with no vsync -> wr_ptr wraps to 0, wr_bank unchanged;
//      then wr_frame_start -> wr_addr=0x80000 (bank 1).
//   T4 rd_frame_start during active rd_req -> rd_addr unchanged until ack;
//      after ack rd_addr = {done_bank,0}.
//   T5 spurious rd_sdram_ack while in S_WR -> no state or address change.
//   T6 assert rst mid-S_WR, then release -> reqs=0, addrs = 0 and 0x80000;
//      the earlier outstanding ack is ignored.

Source files
------------

// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched
//   Burst request scheduler in front of the SDRAM controller. It watches the
//   camera write-FIFO and display read-FIFO fill levels and requests one
//   fixed-length burst at a time. It also keeps the burst base addresses, with
//   two frame banks used ping-pong style so that the display always reads the
//   last frame that was completely written.
//
// Handshake: wr_sdram_req / rd_sdram_req is a level that rises the cycle
//   after the scheduler decides to start a burst. It stays high, with its
//   address held constant, until the controller returns a 1-cycle ack. The
//   request drops on the same clock edge that samples the ack. Only one
//   request is ever high. An ack for the type that is not active is ignored.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   init_done       controller ready; no new bursts are started while low
//   wr_fifo_usedw   camera write-FIFO fill level
//   rd_fifo_usedw   display read-FIFO fill level
//   wr_frame_start  camera vsync pulse: restart write pointer, swap bank
//   rd_frame_start  display vsync pulse: restart read pointer on done bank
//   wr_sdram_ack    write burst finished (1-cycle pulse)
//   rd_sdram_ack    read burst finished (1-cycle pulse)
//   wr_sdram_req    write burst request
//   rd_sdram_req    read burst request
//   wr_addr         {wr_bank, wr_ptr} write burst base address
//   rd_addr         {rd_bank, rd_ptr} read burst base address
//   state_dbg       current FSM state (IDLE=0, WR=1, RD=2, GAP=3)
module sdram_burst_sched #(
  parameter int BURST_LEN   = 512,
  parameter int FRAME_WORDS = 307200,
  parameter int PTR_W       = 19,
  parameter int FIFO_AW     = 10,
  parameter int RD_LOW      = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic [FIFO_AW-1:0] wr_fifo_usedw,
  input  logic [FIFO_AW-1:0] rd_fifo_usedw,
  input  logic               wr_frame_start,
  input  logic               rd_frame_start,
  input  logic               wr_sdram_ack,
  input  logic               rd_sdram_ack,
  output logic               wr_sdram_req,
  output logic               rd_sdram_req,
  output logic [PTR_W:0]     wr_addr,
  output logic [PTR_W:0]     rd_addr,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [PTR_W-1:0] BURST_STEP = PTR_W'(BURST_LEN);
  localparam logic [PTR_W-1:0] LAST_BURST = PTR_W'(FRAME_WORDS - BURST_LEN);

  state_t           state, state_nxt;
  logic             gap_cnt;
  logic             last_wr;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_bank, rd_bank, done_bank;
  logic             wr_pend, rd_pend;
  logic             wr_need, rd_need;
  logic             wr_done, rd_done;
  logic [PTR_W-1:0] wr_ptr_inc, rd_ptr_inc;

  assign wr_need = 32'(wr_fifo_usedw) >= BURST_LEN;
  assign rd_need = 32'(rd_fifo_usedw) < RD_LOW;

  // A burst completes only on the ack that matches the active request.
  assign wr_done = wr_sdram_req && wr_sdram_ack;
  assign rd_done = rd_sdram_req && rd_sdram_ack;

  // The pointers wrap inside their own bank, so a missing vsync cannot make
  // a burst overrun into the other frame buffer.
  assign wr_ptr_inc = (wr_ptr == LAST_BURST) ? '0 : wr_ptr + BURST_STEP;
  assign rd_ptr_inc = (rd_ptr == LAST_BURST) ? '0 : rd_ptr + BURST_STEP;

  assign wr_addr   = {wr_bank, wr_ptr};
  assign rd_addr   = {rd_bank, rd_ptr};
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (init_done) begin
          if (wr_need && rd_need) state_nxt = last_wr ? S_RD : S_WR;
          else if (wr_need)       state_nxt = S_WR;
          else if (rd_need)       state_nxt = S_RD;
        end
      end
      S_WR:    if (wr_sdram_ack) state_nxt = S_GAP;
      S_RD:    if (rd_sdram_ack) state_nxt = S_GAP;
      S_GAP:   if (gap_cnt)      state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      gap_cnt      <= 1'b0;
      wr_sdram_req <= 1'b0;
      rd_sdram_req <= 1'b0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= (state == S_GAP) && !gap_cnt;
      wr_sdram_req <= (state_nxt == S_WR);
      rd_sdram_req <= (state_nxt == S_RD);
    end
  end

  // While a request is high its address must not move. A vsync seen then is
  // remembered and applied on the ack edge, where it overrides the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b1;
      done_bank <= 1'b1;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      last_wr   <= 1'b0;
    end else begin
      if (wr_done) begin
        wr_pend <= 1'b0;
        last_wr <= 1'b1;
        if (wr_pend || wr_frame_start) begin
          wr_ptr    <= '0;
          wr_bank   <= ~wr_bank;
          done_bank <= wr_bank;
        end else begin
          wr_ptr <= wr_ptr_inc;
        end
      end else if (wr_frame_start) begin
        if (wr_sdram_req) begin
          wr_pend <= 1'b1;
        end else begin
          wr_ptr    <= '0;
          wr_bank   <= ~wr_bank;
          done_bank <= wr_bank;
        end
      end

      // done_bank is read before any same-edge update from the write side.
      if (rd_done) begin
        rd_pend <= 1'b0;
        last_wr <= 1'b0;
        if (rd_pend || rd_frame_start) begin
          rd_ptr  <= '0;
          rd_bank <= done_bank;
        end else begin
          rd_ptr <= rd_ptr_inc;
        end
      end else if (rd_frame_start) begin
        if (rd_sdram_req) begin
          rd_pend <= 1'b1;
        end else begin
          rd_ptr  <= '0;
          rd_bank <= done_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Testbench for sdram_burst_sched. An independent address model predicts
// each burst; the prediction is queued when the burst is provoked and popped
// when the DUT raises a request.
module tb_sdram_burst_sched;

  localparam int BL    = 512;
  localparam int FW    = 307200;
  localparam int PTR_W = 19;
  localparam int W     = PTR_W + 2;   // {is_wr, bank, ptr}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             init_done = 1'b0;
  logic [9:0]       wr_fifo_usedw = '0;
  logic [9:0]       rd_fifo_usedw = 10'd600;
  logic             wr_frame_start = 1'b0;
  logic             rd_frame_start = 1'b0;
  logic             wr_sdram_ack = 1'b0;
  logic             rd_sdram_ack = 1'b0;
  logic             wr_sdram_req, rd_sdram_req;
  logic [PTR_W:0]   wr_addr, rd_addr;
  logic [1:0]       state_dbg;

  logic [W-1:0]     exp_q[$];
  int               n_checks = 0;
  int               n_err = 0;

  // model state
  logic [PTR_W-1:0] m_wr_ptr, m_rd_ptr;
  logic             m_wr_bank, m_rd_bank, m_done_bank;

  sdram_burst_sched dut (
    .clk            (clk),
    .rst            (rst),
    .init_done      (init_done),
    .wr_fifo_usedw  (wr_fifo_usedw),
    .rd_fifo_usedw  (rd_fifo_usedw),
    .wr_frame_start (wr_frame_start),
    .rd_frame_start (rd_frame_start),
    .wr_sdram_ack   (wr_sdram_ack),
    .rd_sdram_ack   (rd_sdram_ack),
    .wr_sdram_req   (wr_sdram_req),
    .rd_sdram_req   (rd_sdram_req),
    .wr_addr        (wr_addr),
    .rd_addr        (rd_addr),
    .state_dbg      (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // model
  function automatic logic [PTR_W:0] m_wr_addr();
    return {m_wr_bank, m_wr_ptr};
  endfunction

  function automatic logic [PTR_W:0] m_rd_addr();
    return {m_rd_bank, m_rd_ptr};
  endfunction

  function automatic void m_reset();
    m_wr_ptr = '0; m_rd_ptr = '0;
    m_wr_bank = 1'b0; m_rd_bank = 1'b1; m_done_bank = 1'b1;
  endfunction

  function automatic void m_wr_fs();
    m_wr_ptr = '0;
    m_done_bank = m_wr_bank;
    m_wr_bank = ~m_wr_bank;
  endfunction

  function automatic void m_rd_fs();
    m_rd_ptr = '0;
    m_rd_bank = m_done_bank;
  endfunction

  function automatic logic [PTR_W-1:0] m_step(input logic [PTR_W-1:0] p);
    int n;
    n = int'(p) + BL;
    if (n >= FW) n = 0;
    return PTR_W'(n);
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    init_done = 1'b0;
    wr_fifo_usedw = '0;
    rd_fifo_usedw = 10'd600;
    exp_q.delete();
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode: 0 plain, 1 same-type vsync during request, 2 spurious other-type
  // ack during request, 3 same-type vsync on the ack edge
  task automatic run_burst(input bit is_wr, input int hold, input int mode,
                           input bit chk_gap, output int waited);
    logic [W-1:0]   exp_v, got_v;
    logic [PTR_W:0] addr0;
    bit             seen;
    exp_q.push_back({is_wr, is_wr ? m_wr_addr() : m_rd_addr()});
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 60) begin
      @(negedge clk);
      waited++;
      if (wr_sdram_req || rd_sdram_req) seen = 1'b1;
    end
    exp_v = exp_q.pop_front();
    if (!seen) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (chk_gap) check("gap_cycles", waited, 3);
    got_v = {wr_sdram_req, wr_sdram_req ? wr_addr : rd_addr};
    check("burst", got_v, exp_v);
    check("one_req", wr_sdram_req & rd_sdram_req, 0);
    addr0 = is_wr ? wr_addr : rd_addr;
    for (int i = 0; i < hold; i++) begin
      if (i == 0 && mode == 1) begin
        if (is_wr) wr_frame_start = 1'b1; else rd_frame_start = 1'b1;
      end
      if (i == 0 && mode == 2) begin
        if (is_wr) rd_sdram_ack = 1'b1; else wr_sdram_ack = 1'b1;
      end
      @(negedge clk);
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      wr_sdram_ack = 1'b0;   rd_sdram_ack = 1'b0;
      check("req_held", is_wr ? wr_sdram_req : rd_sdram_req, 1);
      check("other_low", is_wr ? rd_sdram_req : wr_sdram_req, 0);
      check("addr_frozen", is_wr ? wr_addr : rd_addr, addr0);
      check("other_addr", is_wr ? rd_addr : wr_addr, is_wr ? m_rd_addr() : m_wr_addr());
      if (mode == 2 && i == 0) check("state_kept", state_dbg, is_wr ? 1 : 2);
    end
    if (is_wr) wr_sdram_ack = 1'b1; else rd_sdram_ack = 1'b1;
    if (mode == 3) begin
      if (is_wr) wr_frame_start = 1'b1; else rd_frame_start = 1'b1;
    end
    @(negedge clk);
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    wr_sdram_ack = 1'b0;   rd_sdram_ack = 1'b0;
    check("req_drop", is_wr ? wr_sdram_req : rd_sdram_req, 0);
    if (is_wr) begin
      if (mode == 1 || mode == 3) m_wr_fs(); else m_wr_ptr = m_step(m_wr_ptr);
      check("wr_addr_after_ack", wr_addr, m_wr_addr());
    end else begin
      if (mode == 1 || mode == 3) m_rd_fs(); else m_rd_ptr = m_step(m_rd_ptr);
      check("rd_addr_after_ack", rd_addr, m_rd_addr());
    end
  endtask

  // stimulus
  initial begin
    int  lat;
    bit  seen;
    m_reset();

    // T1: reset values and first write burst
    do_reset();
    check("rst_wr_req", wr_sdram_req, 0);
    check("rst_rd_req", rd_sdram_req, 0);
    check("rst_wr_addr", wr_addr, 20'h00000);
    check("rst_rd_addr", rd_addr, 20'h80000);
    check("rst_state", state_dbg, 0);
    init_done = 1'b1;
    wr_fifo_usedw = 10'd512;
    rd_fifo_usedw = 10'd600;
    run_burst(1'b1, 2, 0, 1'b0, lat);
    wr_fifo_usedw = '0;
    check("t1_latency", lat, 1);
    check("t1_wr_addr", wr_addr, 20'h00200);

    // T2: both needs, alternating priority starting with write
    do_reset();
    init_done = 1'b1;
    wr_fifo_usedw = 10'd512;
    rd_fifo_usedw = 10'd0;
    run_burst(1'b1, 519, 0, 1'b0, lat);
    run_burst(1'b0, 519, 0, 1'b1, lat);
    run_burst(1'b1, 519, 0, 1'b1, lat);
    run_burst(1'b0, 519, 0, 1'b1, lat);
    wr_fifo_usedw = '0;
    rd_fifo_usedw = 10'd600;

    // T3: a full frame of writes without vsync wraps within bank 0
    do_reset();
    init_done = 1'b1;
    wr_fifo_usedw = 10'd512;
    for (int k = 0; k < FW / BL; k++) run_burst(1'b1, 0, 0, k > 0, lat);
    wr_fifo_usedw = '0;
    check("t3_wrap", wr_addr, 20'h00000);
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    m_wr_fs();
    check("t3_bank1", wr_addr, 20'h80000);

    // T4: display vsync during an active read is deferred to the ack
    rd_fifo_usedw = 10'd0;
    run_burst(1'b0, 3, 1, 1'b0, lat);
    rd_fifo_usedw = 10'd600;
    check("t4_rd_addr", rd_addr, 20'h00000);

    // T5: spurious read ack during a write; vsync on the write ack edge
    wr_fifo_usedw = 10'd512;
    run_burst(1'b1, 3, 2, 1'b0, lat);
    run_burst(1'b1, 1, 3, 1'b1, lat);
    wr_fifo_usedw = '0;
    check("t5_fs_on_ack", wr_addr, 20'h00000);

    // init_done low: no new bursts
    init_done = 1'b0;
    wr_fifo_usedw = 10'd512;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_req_uninit", wr_sdram_req | rd_sdram_req, 0);
    end
    init_done = 1'b1;

    // T6: async reset during an outstanding write, then a late ack
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_sdram_req) seen = 1'b1;
    end
    check("t6_req_seen", seen, 1);
    rst = 1'b1;
    wr_fifo_usedw = '0;
    #1;
    check("t6_async_wr_req", wr_sdram_req, 0);
    check("t6_async_wr_addr", wr_addr, 20'h00000);
    check("t6_async_rd_addr", rd_addr, 20'h80000);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    wr_sdram_ack = 1'b1;
    @(negedge clk);
    wr_sdram_ack = 1'b0;
    check("t6_late_ack_state", state_dbg, 0);
    check("t6_late_ack_req", wr_sdram_req | rd_sdram_req, 0);
    check("t6_wr_addr", wr_addr, m_wr_addr());
    check("t6_rd_addr", rd_addr, m_rd_addr());

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
